// File: rtl/q15_pkg.sv
// Shared Q0.15 fixed-point definitions and the product-to-Q0.15 conversion helper.
package q15_pkg;

  localparam int unsigned Q15_W   = 16;
  localparam int unsigned PROD_W  = 32;
  localparam logic [Q15_W-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [Q15_W-1:0] Q15_MIN = 16'h8000;

  typedef struct packed {
    logic             sat;
    logic [Q15_W-1:0] data;
  } q15_res_t;

  // Q1.30 product -> Q0.15: drop 15 LSBs (floor), saturate when the two top bits disagree.
  // A signed 16x16 multiply can only overflow positively (0x8000 * 0x8000).
  function automatic q15_res_t q15_sat_trunc(input logic [PROD_W-1:0] prod);
    q15_res_t res;
    if (prod[PROD_W-1] != prod[PROD_W-2]) begin
      res.sat  = 1'b1;
      res.data = Q15_MAX;
    end else begin
      res.sat  = 1'b0;
      res.data = prod[PROD_W-2 -: Q15_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic            w_hi_hit;
  logic [IdxW-1:0] w_hi_idx;
  logic            w_lo_hit;
  logic [IdxW-1:0] w_lo_idx;

  // Scan downward so the last hit is the lowest index; track it both overall and at/above ptr.
  always_comb begin
    w_hi_hit = 1'b0;
    w_hi_idx = '0;
    w_lo_hit = 1'b0;
    w_lo_idx = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        w_lo_hit = 1'b1;
        w_lo_idx = IdxW'(k);
        if (k >= int'(ptr_i)) begin
          w_hi_hit = 1'b1;
          w_hi_idx = IdxW'(k);
        end
      end
    end
  end

  // Requests at/above the pointer win; otherwise wrap to the lowest requester.
  always_comb begin
    gnt_idx_o = w_hi_hit ? w_hi_idx : w_lo_idx;
    gnt_o     = w_lo_hit ? (N'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/q15_mult_arbiter.sv
// Round-robin sharing of one pipelined Q0.15 multiplier between N_REQ requesters, with an ID
// shadow pipeline aligned to the multiplier latency and a registered saturating output stage.
module q15_mult_arbiter
  import q15_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MULT_LAT = 3,
  parameter int unsigned ID_W     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [Q15_W*N_REQ-1:0] req_a_i,
  input  logic [Q15_W*N_REQ-1:0] req_b_i,
  output logic [Q15_W-1:0]       mul_a_o,
  output logic [Q15_W-1:0]       mul_b_o,
  input  logic [PROD_W-1:0]      mul_p_i,
  output logic                   rsp_valid_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [Q15_W-1:0]       rsp_data_o,
  output logic                   rsp_sat_o,
  output logic [3:0]             inflight_o
);

  localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra stage covers the operand register in front of the multiplier.
  localparam int unsigned Depth = MULT_LAT + 1;

  logic [N_REQ-1:0]           w_req_en;
  logic [N_REQ-1:0]           w_gnt;
  logic [IdxW-1:0]            w_gnt_idx;
  logic [IdxW-1:0]            w_ptr_nxt;
  logic                       w_hs;
  logic [Q15_W-1:0]           w_a;
  logic [Q15_W-1:0]           w_b;
  q15_res_t                   w_res;

  logic [IdxW-1:0]            r_ptr;
  logic [Q15_W-1:0]           r_mul_a;
  logic [Q15_W-1:0]           r_mul_b;
  logic [Depth-1:0]           r_sh_vld;
  logic [Depth-1:0][ID_W-1:0] r_sh_id;
  logic                       r_rsp_valid;
  logic [ID_W-1:0]            r_rsp_id;
  logic [Q15_W-1:0]           r_rsp_data;
  logic                       r_rsp_sat;
  logic [3:0]                 r_inflight;

  assign w_req_en = req_valid_i & {N_REQ{en_i}};

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i     (w_req_en),
    .ptr_i     (r_ptr),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  // Grant is only ever raised on a valid requester, so any grant is a handshake.
  assign w_hs        = |w_gnt;
  assign req_ready_o = w_gnt;
  assign w_ptr_nxt   = (w_gnt_idx == IdxW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_res       = q15_sat_trunc(mul_p_i);

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (w_gnt[k]) begin
        w_a = req_a_i[Q15_W*k +: Q15_W];
        w_b = req_b_i[Q15_W*k +: Q15_W];
      end
    end
  end

  // Round-robin pointer advances past the granted requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Operand registers load on handshake and otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (w_hs) begin
      r_mul_a <= w_a;
      r_mul_b <= w_b;
    end
  end

  // Shadow pipeline of {valid, id}, shifting every cycle in step with the multiplier.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sh_vld <= '0;
      r_sh_id  <= '0;
    end else begin
      r_sh_vld <= {r_sh_vld[Depth-2:0], w_hs};
      r_sh_id  <= {r_sh_id[Depth-2:0], ID_W'(w_gnt_idx)};
    end
  end

  // Registered response: data/id hold between results, sat flag is a pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_sat   <= 1'b0;
    end else if (r_sh_vld[Depth-1]) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_sh_id[Depth-1];
      r_rsp_data  <= w_res.data;
      r_rsp_sat   <= w_res.sat;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_sat   <= 1'b0;
    end
  end

  // Outstanding-operation counter: accepted but not yet returned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_hs, r_rsp_valid})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign mul_a_o     = r_mul_a;
  assign mul_b_o     = r_mul_b;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_sat_o   = r_rsp_sat;
  assign inflight_o  = r_inflight;

endmodule

// File: tb/tb_q15_mult_arbiter.sv
// Bench for q15_mult_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_q15_mult_arbiter;

  localparam int N = 4;
  localparam int L = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [63:0]   req_a;
  logic [63:0]   req_b;
  logic [15:0]   mul_a;
  logic [15:0]   mul_b;
  logic [31:0]   mul_p;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          rsp_sat;
  logic [3:0]    inflight;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
    logic        sat;
  } exp_t;

  exp_t        exp_q[$];
  int          rr = 0;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  always #5 clk = ~clk;

  q15_mult_arbiter #(
    .N_REQ    (N),
    .MULT_LAT (L),
    .ID_W     (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_p_i     (mul_p),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_sat_o   (rsp_sat),
    .inflight_o  (inflight)
  );

  // Behavioural L-deep signed multiplier standing in for the IP.
  logic [31:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= {{16{mul_a[15]}}, mul_a} * {{16{mul_b[15]}}, mul_b};
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[L-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected Q0.15 result from integer arithmetic: floor(a*b / 2^15), clipped at +max.
  function automatic logic [16:0] ref_q15(input logic [15:0] a, input logic [15:0] b);
    int sa, sb, p, q;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    q  = p >>> 15;
    if (q > 32767) return {1'b1, 16'h7FFF};
    return {1'b0, q[15:0]};
  endfunction

  // Per-cycle check at the negedge, then advance the transaction model.
  task automatic check_cycle();
    int          g;
    logic [31:0] exp_rdy;
    logic [16:0] r;
    exp_t        e;
    g = -1;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (rr + i) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
    check_eq("inflight", 32'(inflight), 32'(exp_q.size()));
    check_eq("ready", 32'(req_ready), exp_rdy);
    check_eq("mul_a", 32'(mul_a), 32'(last_a));
    check_eq("mul_b", 32'(mul_b), 32'(last_b));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
      check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
      check_eq("rsp_sat", 32'(rsp_sat), 32'(e.sat));
    end else begin
      check_eq("rsp_idle", 32'(rsp_valid), 32'd0);
      check_eq("sat_idle", 32'(rsp_sat), 32'd0);
    end
    if (g >= 0) begin
      last_a = req_a[16*g +: 16];
      last_b = req_b[16*g +: 16];
      r      = ref_q15(last_a, last_b);
      e.due  = cyc + L + 2;
      e.id   = g;
      e.data = r[15:0];
      e.sat  = r[16];
      exp_q.push_back(e);
      rr = (g + 1) % N;
    end
    cyc++;
  endtask

  // Inputs are applied just after a posedge; checks happen on the following negedge.
  task automatic step(input logic [N-1:0] v, input logic e, input logic [63:0] a,
                      input logic [63:0] b);
    req_valid = v;
    en        = e;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    en        = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_data", 32'(rsp_data), 32'd0);
    check_eq("rst_id", 32'(rsp_id), 32'd0);
    check_eq("rst_sat", 32'(rsp_sat), 32'd0);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_mul_a", 32'(mul_a), 32'd0);
    check_eq("rst_mul_b", 32'(mul_b), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    rr     = 0;
    last_a = '0;
    last_b = '0;
    cyc++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  function automatic logic [63:0] rand_ops();
    return {rand_op(), rand_op(), rand_op(), rand_op()};
  endfunction

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single op and saturation corners on requester 0.
    step(4'b0001, 1'b1, 64'h4000, 64'h4000);
    repeat (6) step(4'b0000, 1'b1, 64'h0, 64'h0);
    step(4'b0001, 1'b1, 64'h8000, 64'h8000);
    step(4'b0001, 1'b1, 64'h8000, 64'h7FFF);
    step(4'b0001, 1'b1, 64'hFFFF, 64'h0001);
    repeat (6) step(4'b0000, 1'b1, 64'h0, 64'h0);

    // Fairness: everyone requesting for 8 cycles.
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, rand_ops(), rand_ops());
    repeat (6) step(4'b0000, 1'b1, 64'h0, 64'h0);

    // Pointer skip: move pointer to 2, then only req0/req1 valid.
    step(4'b0010, 1'b1, rand_ops(), rand_ops());
    step(4'b0011, 1'b1, rand_ops(), rand_ops());
    step(4'b0011, 1'b1, rand_ops(), rand_ops());
    step(4'b1111, 1'b1, rand_ops(), rand_ops());

    // Enable low mid-stream for 3 cycles, then drain.
    step(4'b1111, 1'b1, rand_ops(), rand_ops());
    repeat (3) step(4'b1111, 1'b0, rand_ops(), rand_ops());
    repeat (8) step(4'b0000, 1'b1, 64'h0, 64'h0);
    check_eq("drained", 32'(inflight), 32'd0);

    // Reset with ops in flight; first post-reset grant must be req0.
    repeat (4) step(4'b1111, 1'b1, rand_ops(), rand_ops());
    do_reset();
    step(4'b1110, 1'b0, rand_ops(), rand_ops());
    step(4'b1111, 1'b1, rand_ops(), rand_ops());
    repeat (8) step(4'b0000, 1'b1, 64'h0, 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0), rand_ops(), rand_ops());
    end
    repeat (10) step(4'b0000, 1'b1, 64'h0, 64'h0);
    check_eq("final_inflight", 32'(inflight), 32'd0);
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
